timer_controller: RTL and testbench
===================================

# timer_controller

Programmable interval timer controller that sequences a WIDTH-bit up-counter through start/hold/stop phases, with a prescaler, one-shot or periodic expiry, and an expiry pulse. It sits beside the free-running counter datapath and replaces ad-hoc reset-driven counting with a software-controllable timer. It is the single owner of the count register and its enable.

## Interface
- WIDTH, 32, count and period width
- PRESCALE_W, 8, prescaler divisor width
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-low (rst=0 resets)
- start  input  1  level-sampled each edge; (re)launch timer with current cfg_*
- stop  input  1  abort to IDLE
- hold  input  1  freeze count while high (RUN only)
- cfg_period  input  WIDTH  terminal count N
- cfg_prescale  input  PRESCALE_W  divisor P; count advances every P+1 cycles
- cfg_periodic  input  1  1 = auto-reload, 0 = one-shot
- count  output  WIDTH  current count value
- busy  output  1  high in RUN or HOLD
- tick  output  1  one-cycle expiry pulse
- done  output  1  high in DONE (one-shot expired)

## Operation
- States: IDLE, RUN, HOLD, DONE (encoded in the shared package).
- Command priority per edge: stop > start > hold.
- start in any state: latch cfg_period, cfg_prescale, cfg_periodic into shadow registers; count<=0, prescaler<=0; go RUN. cfg_* changes after launch have no effect until the next start.
- RUN: prescaler counts 0..P; on prescaler==P (the enable), prescaler<=0 and count advances.
- Enable with count<N: count<=count+1.
- Enable with count==N (expiry): tick<=1 for one cycle; periodic: count<=0, stay RUN; one-shot: count held at N, go DONE.
- N=0: expiry on every enable.
- hold=1 in RUN: go HOLD; prescaler and count frozen. hold=0 in HOLD: return to RUN and resume from the frozen prescaler value. hold ignored in IDLE and DONE.
- stop in any state: go IDLE, count<=0, prescaler<=0, tick<=0.
- DONE: count held at N, done=1 until start or stop.
- Count is unsigned. count never exceeds the shadow N, so no wrap-around past 2^WIDTH-1. N=2^WIDTH-1 is legal.

## Timing
- Reset values: state IDLE, count 0, prescaler 0, shadow regs 0, busy 0, tick 0, done 0.
- All outputs are registered and change only on clk edges or asynchronous reset assertion.
- Start sampled at edge e0 gives busy=1 and count=0 after e0. With P=0, count=1 after e1.
- Expiry interval is (N+1)*(P+1) cycles. The first tick is high in the cycle after edge e0+(N+1)*(P+1).
- start coincident with expiry: start wins; no tick, and the timer restarts at count 0.
- stop coincident with start or expiry: stop wins; no tick.
- hold coincident with an enable edge: the enable is suppressed and HOLD is entered.
- Reset asserted mid-operation: immediate return to reset values. The first start is accepted on the first edge after rst rises.

## Structure
- Package timer_pkg: state enum (IDLE, RUN, HOLD, DONE), default WIDTH/PRESCALE_W localparams.
- Sub-module tick_prescaler: PRESCALE_W counter with clear, freeze and divisor inputs, producing the one-cycle enable.
- timer_controller contains the FSM, shadow registers, count register and expiry compare.

## Test plan
- Reset: hold rst=0 for 2 cycles with start=1, then release -> count=0, busy=0, tick=0, done=0 throughout reset. Start is accepted on the first edge after release.
- Periodic: P=0, N=3, start pulse -> count sequence 0,1,2,3,0,1,..., tick high every 4th cycle, busy=1, done=0.
- One-shot with prescale: P=2, N=2 -> count steps every 3 cycles; a single tick 9 cycles after the start edge; count holds at 2; done=1, busy=0 until the next start.
- Hold: P=0, N=10, hold for 5 cycles at count=4 -> count stays 4 and busy=1 during hold. After release, tick arrives 5 cycles later than without hold.
- Collisions: stop together with expiry -> no tick, count=0, IDLE. Start together with expiry -> no tick, count=0, RUN with new cfg.
- Async reset mid-RUN at count=7 -> all outputs return to reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared timer definitions: FSM state encoding and default widths.
package timer_pkg;

   localparam int DEFAULT_WIDTH      = 32;
   localparam int DEFAULT_PRESCALE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2,
      DONE = 2'd3
   } timer_state_e;

endpackage

// File: rtl/timer_controller_tick_prescaler.sv
// Prescaler for the interval timer. It counts 0..divisor and produces a
// one-cycle enable on the edge where it wraps. The clear input has priority
// over freeze. The enable is combinational, so the owner acts on the same
// edge that wraps the prescaler.
module tick_prescaler
   import timer_pkg::*;
#(
   parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  freeze,
   input  logic [PRESCALE_W-1:0] divisor,
   output logic                  enable
);

   logic [PRESCALE_W-1:0] count_reg;
   logic [PRESCALE_W-1:0] count_next;
   logic                  at_divisor;

   assign at_divisor = (count_reg == divisor);
   assign enable     = !clear && !freeze && at_divisor;

   // Next prescaler value: clear to zero, hold when frozen, else count/wrap.
   always_comb begin
      count_next = count_reg;
      if (clear) begin
         count_next = '0;
      end else if (!freeze) begin
         if (at_divisor) begin
            count_next = '0;
         end else begin
            count_next = count_reg + PRESCALE_W'(1);
         end
      end
   end

   // Prescaler register with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/timer_controller.sv
// Programmable interval timer. It owns the count register and sequences it
// through IDLE/RUN/HOLD/DONE, with a prescaled enable. Expiry can be one-shot
// or periodic, and each expiry gives a one-cycle tick. All outputs come
// straight from flops.
module timer_controller
   import timer_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter int PRESCALE_W = DEFAULT_PRESCALE_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  hold,
   input  logic [WIDTH-1:0]      cfg_period,
   input  logic [PRESCALE_W-1:0] cfg_prescale,
   input  logic                  cfg_periodic,
   output logic [WIDTH-1:0]      count,
   output logic                  busy,
   output logic                  tick,
   output logic                  done
);

   timer_state_e          state_reg, state_next;
   logic [WIDTH-1:0]      count_reg, count_next;
   logic [WIDTH-1:0]      period_reg, period_next;
   logic [PRESCALE_W-1:0] prescale_reg, prescale_next;
   logic                  periodic_reg, periodic_next;
   logic                  tick_reg, tick_next;
   logic                  busy_reg, busy_next;
   logic                  done_reg, done_next;

   logic                  counting;
   logic                  presc_clear;
   logic                  presc_enable;

   // The timer advances only in RUN, or when HOLD is released. stop/start
   // pre-empt counting and restart the prescaler from zero.
   assign counting    = ((state_reg == RUN) || (state_reg == HOLD)) && !hold
                        && !stop && !start;
   assign presc_clear = stop || start;

   tick_prescaler #(
      .PRESCALE_W(PRESCALE_W)
   ) u_prescaler (
      .clk     (clk),
      .rst     (rst),
      .clear   (presc_clear),
      .freeze  (!counting),
      .divisor (prescale_reg),
      .enable  (presc_enable)
   );

   // Next-state, count, shadow and flag logic; priority stop > start > hold.
   always_comb begin
      state_next    = state_reg;
      count_next    = count_reg;
      period_next   = period_reg;
      prescale_next = prescale_reg;
      periodic_next = periodic_reg;
      tick_next     = 1'b0;

      if (stop) begin
         state_next = IDLE;
         count_next = '0;
      end else if (start) begin
         state_next    = RUN;
         count_next    = '0;
         period_next   = cfg_period;
         prescale_next = cfg_prescale;
         periodic_next = cfg_periodic;
      end else begin
         case (state_reg)
            RUN, HOLD: begin
               if (hold) begin
                  state_next = HOLD;
               end else begin
                  state_next = RUN;
                  if (presc_enable) begin
                     if (count_reg == period_reg) begin
                        tick_next = 1'b1;
                        if (periodic_reg) begin
                           count_next = '0;
                        end else begin
                           state_next = DONE;
                        end
                     end else begin
                        count_next = count_reg + WIDTH'(1);
                     end
                  end
               end
            end
            default: begin
               state_next = state_reg;
            end
         endcase
      end

      busy_next = (state_next == RUN) || (state_next == HOLD);
      done_next = (state_next == DONE);
   end

   // State, count, shadow configuration and output flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         count_reg    <= '0;
         period_reg   <= '0;
         prescale_reg <= '0;
         periodic_reg <= 1'b0;
         tick_reg     <= 1'b0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
      end else begin
         state_reg    <= state_next;
         count_reg    <= count_next;
         period_reg   <= period_next;
         prescale_reg <= prescale_next;
         periodic_reg <= periodic_next;
         tick_reg     <= tick_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
      end
   end

   assign count = count_reg;
   assign tick  = tick_reg;
   assign busy  = busy_reg;
   assign done  = done_reg;

endmodule

// File: tb/tb_timer_controller.sv
// Directed testbench for timer_controller with hand-computed expectations.
module tb_timer_controller;

   localparam int WIDTH      = 32;
   localparam int PRESCALE_W = 8;

   logic                  clk;
   logic                  rst;
   logic                  start;
   logic                  stop;
   logic                  hold;
   logic [WIDTH-1:0]      cfg_period;
   logic [PRESCALE_W-1:0] cfg_prescale;
   logic                  cfg_periodic;
   logic [WIDTH-1:0]      count;
   logic                  busy;
   logic                  tick;
   logic                  done;

   int n_vec;
   int n_err;

   timer_controller #(
      .WIDTH      (WIDTH),
      .PRESCALE_W (PRESCALE_W)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .stop         (stop),
      .hold         (hold),
      .cfg_period   (cfg_period),
      .cfg_prescale (cfg_prescale),
      .cfg_periodic (cfg_periodic),
      .count        (count),
      .busy         (busy),
      .tick         (tick),
      .done         (done)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every vector and reports a miscompare.
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   // Advance one rising edge and settle 1 ns after it before sampling.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [31:0] e_count,
                            input logic e_busy, input logic e_tick, input logic e_done);
      check({tag, ".count"}, count, e_count);
      check({tag, ".busy"},  32'(busy), 32'(e_busy));
      check({tag, ".tick"},  32'(tick), 32'(e_tick));
      check({tag, ".done"},  32'(done), 32'(e_done));
   endtask

   task automatic launch(input logic [31:0] n, input logic [7:0] p, input logic periodic);
      cfg_period   = n;
      cfg_prescale = p;
      cfg_periodic = periodic;
      start        = 1'b1;
      step();
      start        = 1'b0;
   endtask

   initial begin
      int per_cnt [8];
      int per_tck [8];
      int os_cnt  [12];
      n_vec = 0;
      n_err = 0;
      per_cnt = '{1, 2, 3, 0, 1, 2, 3, 0};
      per_tck = '{0, 0, 0, 1, 0, 0, 0, 1};
      os_cnt  = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 2, 2};

      // Reset held with start asserted; outputs must stay at reset values.
      rst          = 1'b0;
      start        = 1'b1;
      stop         = 1'b0;
      hold         = 1'b0;
      cfg_period   = 32'd3;
      cfg_prescale = 8'd0;
      cfg_periodic = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         step();
         check_all($sformatf("rst%0d", i), 0, 1'b0, 1'b0, 1'b0);
      end
      rst = 1'b1;
      // First edge after release accepts start.
      step();
      start = 1'b0;
      check_all("rst_start", 0, 1'b1, 1'b0, 1'b0);

      // Periodic, P=0, N=3.
      for (int i = 0; i < 8; i++) begin
         step();
         check_all($sformatf("per_e%0d", i + 1), 32'(per_cnt[i]), 1'b1,
                   per_tck[i][0], 1'b0);
      end

      // Stop returns to idle.
      stop = 1'b1;
      step();
      stop = 1'b0;
      check_all("stop", 0, 1'b0, 1'b0, 1'b0);

      // One-shot with prescale, P=2, N=2: single tick 9 edges after start.
      launch(32'd2, 8'd2, 1'b0);
      check_all("os_e0", 0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) begin
         step();
         check_all($sformatf("os_e%0d", i + 1), 32'(os_cnt[i]), i < 8,
                   i == 8, i >= 8);
      end

      // Hold for 5 edges at count 4, P=0, N=10 one-shot: tick at edge 16.
      launch(32'd10, 8'd0, 1'b0);
      for (int i = 1; i <= 4; i++) step();
      check("hold_pre.count", count, 32'd4);
      hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("hold%0d.count", i), count, 32'd4);
         check($sformatf("hold%0d.busy", i), 32'(busy), 32'd1);
      end
      hold = 1'b0;
      for (int i = 10; i <= 15; i++) begin
         step();
         check_all($sformatf("hold_e%0d", i), 32'(i - 5), 1'b1, 1'b0, 1'b0);
      end
      step();
      check_all("hold_e16", 32'd10, 1'b0, 1'b1, 1'b1);

      // stop coincident with expiry, P=0, N=2 periodic.
      launch(32'd2, 8'd0, 1'b1);
      step();
      step();
      check("sx_pre.count", count, 32'd2);
      stop = 1'b1;
      step();
      stop = 1'b0;
      check_all("sx", 0, 1'b0, 1'b0, 1'b0);
      step();
      check_all("sx_after", 0, 1'b0, 1'b0, 1'b0);

      // start coincident with expiry, new cfg N=5 one-shot.
      launch(32'd2, 8'd0, 1'b1);
      step();
      step();
      check("stx_pre.count", count, 32'd2);
      launch(32'd5, 8'd0, 1'b0);
      check_all("stx", 0, 1'b1, 1'b0, 1'b0);
      // Config changes after launch must be ignored.
      cfg_period   = 32'd1;
      cfg_periodic = 1'b1;
      for (int i = 1; i <= 5; i++) step();
      check_all("stx_e5", 32'd5, 1'b1, 1'b0, 1'b0);
      step();
      check_all("stx_e6", 32'd5, 1'b0, 1'b1, 1'b1);

      // N=0 with P=1: expiry on every enable, i.e. every second edge.
      launch(32'd0, 8'd1, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         step();
         check_all($sformatf("n0_e%0d", i), 0, 1'b1, (i % 2) == 0, 1'b0);
      end

      // Asynchronous reset mid-RUN at count 7.
      launch(32'd20, 8'd0, 1'b1);
      for (int i = 1; i <= 7; i++) step();
      check("ar_pre.count", count, 32'd7);
      #2;
      rst = 1'b0;
      #1;
      check_all("ar", 0, 1'b0, 1'b0, 1'b0);
      step();
      rst = 1'b1;
      step();
      check_all("ar_idle", 0, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
